// File: rtl/flp_add_sched.sv
// Round-robin front end that shares one external pipelined FP32 adder among
// four requesters and steers each result back to the requester it belongs to.
module flp_add_sched #(
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [3:0]   i_req_valid,
  input  logic [127:0] i_req_a,
  input  logic [127:0] i_req_b,
  output logic [3:0]   o_req_ready,
  output logic         o_add_valid,
  output logic [31:0]  o_add_a,
  output logic [31:0]  o_add_b,
  input  logic [31:0]  i_add_p,
  output logic [3:0]   o_rsp_valid,
  output logic [31:0]  o_rsp_p,
  output logic         o_busy
);

  logic [1:0]     ptr_q;
  logic [1:0]     idx;
  logic [1:0]     grant_id;
  logic           accept;
  logic [1:0]     add_id_q;
  logic [LAT-1:0] tag_v_q;
  logic [1:0]     tag_id_q [LAT];
  logic [3:0]     cnt_q;

  // Scan from the far end of the rotation so the requester closest to the
  // pointer is the last match and therefore wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    o_req_ready = '0;
    grant_id    = ptr_q;
    accept      = 1'b0;
    idx         = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (i_req_valid[idx]) begin
        grant_id = idx;
        accept   = 1'b1;
      end
    end
    if (accept) o_req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr_q       <= 2'd0;
      o_add_valid <= 1'b0;
      o_add_a     <= '0;
      o_add_b     <= '0;
      add_id_q    <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      o_add_valid <= accept;
      if (accept) begin
        o_add_a  <= i_req_a[32*grant_id +: 32];
        o_add_b  <= i_req_b[32*grant_id +: 32];
        add_id_q <= grant_id;
        ptr_q    <= grant_id + 2'd1;
      end
    end
  end

  // Tag pipeline runs in lockstep with the adder: tag stage LAT-1 lines up
  // with the cycle in which i_add_p carries that operation's result.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tag_v_q <= '0;
    end else begin
      tag_v_q[0] <= o_add_valid;
      for (int k = 1; k < LAT; k++) tag_v_q[k] <= tag_v_q[k-1];
    end
  end

  // NOTE: only the valid bits are reset; ids are ignored while invalid, so they are plain flops.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= add_id_q;
    for (int k = 1; k < LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      o_rsp_valid <= '0;
      o_rsp_p     <= '0;
      cnt_q       <= 4'd0;
    end else begin
      o_rsp_valid <= '0;
      if (tag_v_q[LAT-1]) begin
        o_rsp_valid <= 4'b0001 << tag_id_q[LAT-1];
        o_rsp_p     <= i_add_p;
      end
      case ({accept, |o_rsp_valid})
        2'b10:   cnt_q <= cnt_q + 4'd1;
        2'b01:   cnt_q <= cnt_q - 4'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign o_busy = (cnt_q != 4'd0);

endmodule

// File: tb/tb_flp_add_sched.sv
// Scoreboard bench for flp_add_sched: three instances (LAT 3, 1, 8) share the
// request stimulus; each has its own adder model and response monitor.
module tb_flp_add_sched;

  localparam int NV = 10;
  localparam int LATS [3] = '{3, 1, 8};
  localparam logic [31:0] VA [NV] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3FC00000,
    32'h3F000000, 32'h40400000, 32'h40000000, 32'h40800000, 32'h3F800000, 32'h7FC00000};
  localparam logic [31:0] VB [NV] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h3FC00000,
    32'h3F000000, 32'h3F800000, 32'h40800000, 32'h40800000, 32'hBF800000, 32'h3F800000};
  // Hand-computed FP32 sums of VA[k] + VB[k].
  localparam logic [31:0] VS [NV] = '{32'h40400000, 32'h40000000, 32'h40800000, 32'h40400000,
    32'h3F800000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h00000000, 32'h7FC00000};

  typedef struct {
    logic [1:0]  id;
    logic [31:0] p;
    int          acc_cyc;
    logic [2:0]  mask;
  } exp_t;

  logic         clk = 1'b0;
  logic         nrst;
  logic [3:0]   req_valid;
  logic [127:0] req_a, req_b;
  logic [3:0]   rdy   [3];
  logic         add_v [3];
  logic [31:0]  add_a [3];
  logic [31:0]  add_b [3];
  logic [3:0]   rsp_v [3];
  logic [31:0]  rsp_p [3];
  logic         busy  [3];
  logic         peak_en = 1'b0;

  exp_t exp_q [$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < NV; k++)
      if (VA[k] == a && VB[k] == b) return VS[k];
    return 32'hDEADBEEF;
  endfunction

  function automatic int nexp(input int i);
    int n = 0;
    foreach (exp_q[k]) if (exp_q[k].mask[i]) n++;
    return n;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int L = LATS[gi];
    logic [31:0] pipe [L];
    logic [31:0] add_p;
    int          got = 0;
    int          peak = 0;
    int          nxt = 0;
    int          j;

    flp_add_sched #(.LAT(L)) u_dut (
      .clk         (clk),
      .nrst        (nrst),
      .i_req_valid (req_valid),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .o_req_ready (rdy[gi]),
      .o_add_valid (add_v[gi]),
      .o_add_a     (add_a[gi]),
      .o_add_b     (add_b[gi]),
      .i_add_p     (add_p),
      .o_rsp_valid (rsp_v[gi]),
      .o_rsp_p     (rsp_p[gi]),
      .o_busy      (busy[gi])
    );

    // External adder: never reset, result appears exactly L cycles after issue.
    assign add_p = pipe[L-1];
    always @(posedge clk) begin
      pipe[0] <= add_v[gi] ? add_model(add_a[gi], add_b[gi]) : 32'hDEADBEEF;
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end

    always @(negedge clk) begin
      if (!peak_en) peak <= 0;
      else if (int'(u_dut.cnt_q) > peak) peak <= int'(u_dut.cnt_q);
      if (rsp_v[gi] != 4'b0000) begin
        j = nxt;
        while (j < exp_q.size() && !exp_q[j].mask[gi]) j++;
        if (j >= exp_q.size()) begin
          check($sformatf("L%0d rsp_unexpected", L), {28'b0, rsp_v[gi]}, 32'd0);
        end else begin
          check($sformatf("L%0d rsp_valid", L), {28'b0, rsp_v[gi]}, {28'b0, 4'b0001 << exp_q[j].id});
          check($sformatf("L%0d rsp_p", L), rsp_p[gi], exp_q[j].p);
          check($sformatf("L%0d rsp_latency", L), 32'(cyc - exp_q[j].acc_cyc), 32'(L + 2));
          nxt <= j + 1;
          got <= got + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of requests; lane n carries vector (base+n)%NV.
  task automatic issue(input logic [3:0] v, input int base, input logic [3:0] exp_rdy,
                       input logic [2:0] mask);
    exp_t e;
    req_valid = v;
    for (int n = 0; n < 4; n++) begin
      req_a[32*n +: 32] = VA[(base + n) % NV];
      req_b[32*n +: 32] = VB[(base + n) % NV];
    end
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("L%0d req_ready", LATS[i]), {28'b0, rdy[i]}, {28'b0, exp_rdy});
    if (exp_rdy != 4'b0000) begin
      e.id = 2'd0;
      for (int n = 0; n < 4; n++) if (exp_rdy[n]) e.id = 2'(n);
      e.p       = VS[(base + int'(e.id)) % NV];
      e.acc_cyc = cyc;
      e.mask    = mask;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    tick();
    req_valid = 4'b0000;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    nrst = 1'b0;
    req_valid = 4'b0000;
    req_a = '0;
    req_b = '0;

    // Reset values; grant with all requesters valid reflects pointer 0.
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset add_valid", {31'b0, add_v[i]}, 32'd0);
      check("reset add_a", add_a[i], 32'd0);
      check("reset add_b", add_b[i], 32'd0);
      check("reset rsp_valid", {28'b0, rsp_v[i]}, 32'd0);
      check("reset rsp_p", rsp_p[i], 32'd0);
      check("reset busy", {31'b0, busy[i]}, 32'd0);
      check("reset req_ready", {28'b0, rdy[i]}, 32'd1);
    end
    req_valid = 4'b0000;
    tick();
    nrst = 1'b1;

    // Single op from requester 2 (lane 2 = vector 0: 1.0 + 2.0).
    tick();
    issue(4'b0100, 8, 4'b0100, 3'b111);
    tick();
    req_valid = 4'b0000;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("L%0d busy c%0d", LATS[i], k), {31'b0, busy[i]}, {31'b0, k <= LATS[i] + 2});
        if (k == 1) begin
          check("issue add_valid", {31'b0, add_v[i]}, 32'd1);
          check("issue add_a", add_a[i], 32'h3F800000);
          check("issue add_b", add_b[i], 32'h40000000);
        end
        if (k == 2) begin
          check("idle add_valid", {31'b0, add_v[i]}, 32'd0);
          check("hold add_a", add_a[i], 32'h3F800000);
        end
      end
    end

    // Full contention from reset: grants rotate 0,1,2,3,0,1,2,3.
    tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      issue(4'b1111, k, 4'b0001 << (k % 4), 3'b111);
    end
    idle(14);

    // Pointer skip: park pointer at 3, then only 1 and 2 request.
    tick(); issue(4'b0100, 8, 4'b0100, 3'b111);
    tick(); issue(4'b0110, 3, 4'b0010, 3'b111);
    tick(); issue(4'b0110, 5, 4'b0100, 3'b111);
    tick(); issue(4'b1001, 7, 4'b1000, 3'b111);
    idle(14);

    // Back-to-back requester 0; in-flight count peaks at min(6, LAT+2).
    peak_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      issue(4'b0001, k + 2, 4'b0001, 3'b111);
    end
    idle(14);
    check("L3 peak in-flight", 32'(g_inst[0].peak), 32'd5);
    check("L1 peak in-flight", 32'(g_inst[1].peak), 32'd3);
    check("L8 peak in-flight", 32'(g_inst[2].peak), 32'd6);
    peak_en = 1'b0;

    // Reset mid-flight: only LAT=1 returns its first op before reset lands.
    for (int k = 0; k < 3; k++) begin
      tick();
      issue(4'b0010, k, 4'b0010, (k == 0) ? 3'b010 : 3'b000);
    end
    tick();
    req_valid = 4'b0000;
    tick();
    nrst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("midreset busy", {31'b0, busy[i]}, 32'd0);
      check("midreset rsp_valid", {28'b0, rsp_v[i]}, 32'd0);
    end
    tick();
    nrst = 1'b1;
    issue(4'b1111, 0, 4'b0001, 3'b111);
    idle(16);

    for (int i = 0; i < 3; i++) check($sformatf("L%0d final busy", LATS[i]), {31'b0, busy[i]}, 32'd0);
    check("L3 responses", 32'(g_inst[0].got), 32'(nexp(0)));
    check("L1 responses", 32'(g_inst[1].got), 32'(nexp(1)));
    check("L8 responses", 32'(g_inst[2].got), 32'(nexp(2)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
